// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one RGB LED between three status requesters.
//   Round-robin grant with a minimum display time, a dark gap between owners,
//   per-requester blink and a global PWM brightness.
// Ports:
//   CLK      system clock
//   RST      synchronous reset, active-high
//   REQ      [2:0] per-requester LED request
//   COLOR0-2 [2:0] per-requester colour {R,G,B}
//   BLINK    [2:0] per-requester blink enable
//   BRIGHT   [7:0] global PWM duty (0 = dark, 255 = 255/256 on)
//   GNT      [2:0] one-hot current owner, 000 when none
//   BUSY     high while showing an owner or during the dark gap
//   LED_RGB  [2:0] registered LED drive {R,G,B}, active-high
module rgb_led_arbiter #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned HOLD_TICKS  = 500,
  parameter int unsigned GAP_TICKS   = 100,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [2:0] COLOR0,
  input  logic [2:0] COLOR1,
  input  logic [2:0] COLOR2,
  input  logic [2:0] BLINK,
  input  logic [7:0] BRIGHT,
  output logic [2:0] GNT,
  output logic       BUSY,
  output logic [2:0] LED_RGB
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned GapW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0]  HoldInit = HoldW'(HOLD_TICKS);
  localparam logic [GapW-1:0]   GapInit  = GapW'(GAP_TICKS);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_TICKS - 1);

  // StArb holds the winner picked in IDLE for one cycle before the grant.
  typedef enum logic [1:0] {StIdle, StArb, StShow, StGap} state_e;

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        pick_q, pick_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic              blink_en_q, blink_en_d;
  logic [2:0]        color_q, color_d;
  logic [7:0]        pwm_q, pwm_d;
  logic [2:0]        led_q, led_d;

  logic       tick;
  logic [1:0] arb_idx;
  logic [2:0] owner_mask;
  logic       hold_done;
  logic       grant;
  logic [1:0] grant_idx;

  // Round-robin: search starts at (last + 1) mod 3; the lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign tick       = (presc_q == PrescMax);
  assign arb_idx    = rr_pick(REQ, owner_q);
  assign owner_mask = 3'(3'b001 << owner_q);
  // Expires on the edge of the last tick so a grant lasts exactly HOLD_TICKS ticks.
  assign hold_done  = (hold_q == '0) || (tick && (hold_q == HoldW'(1)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    pick_d      = pick_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    hold_d      = hold_q;
    gap_d       = gap_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    blink_en_d  = blink_en_q;
    color_d     = color_q;
    pwm_d       = pwm_q + 8'd1;
    grant       = 1'b0;
    grant_idx   = arb_idx;

    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          pick_d  = arb_idx;
          state_d = StArb;
        end
      end
      StArb: begin
        grant     = 1'b1;
        grant_idx = pick_q;
      end
      StShow: begin
        if (tick) begin
          if (hold_q != '0) hold_d = hold_q - 1'b1;
          if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        // Leave when hold is over and either the owner let go or someone else waits.
        if (hold_done && (((REQ & owner_mask) == 3'b000) || ((REQ & ~owner_mask) != 3'b000))) begin
          if (GAP_TICKS == 0) begin
            if (|REQ) grant = 1'b1;
            else      state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapInit;
            presc_d = '0;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (gap_q <= GapW'(1)) begin
            if (|REQ) grant = 1'b1;
            else      state_d = StIdle;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant) begin
      state_d     = StShow;
      owner_d     = grant_idx;
      hold_d      = HoldInit;
      blink_on_d  = 1'b1;
      blink_cnt_d = '0;
      presc_d     = '0;
      case (grant_idx)
        2'd0:    begin color_d = COLOR0; blink_en_d = BLINK[0]; end
        2'd1:    begin color_d = COLOR1; blink_en_d = BLINK[1]; end
        default: begin color_d = COLOR2; blink_en_d = BLINK[2]; end
      endcase
    end
  end

  always_comb begin
    led_d = 3'b000;
    if ((state_q == StShow) && (pwm_q < BRIGHT) && (blink_on_q || !blink_en_q)) begin
      led_d = color_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      owner_q     <= 2'd2;
      pick_q      <= 2'd0;
      presc_q     <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      blink_en_q  <= 1'b0;
      color_q     <= 3'b000;
      pwm_q       <= 8'd0;
      led_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      pick_q      <= pick_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      blink_en_q  <= blink_en_d;
      color_q     <= color_d;
      pwm_q       <= pwm_d;
      led_q       <= led_d;
    end
  end

  assign GNT     = (state_q == StShow) ? owner_mask : 3'b000;
  assign BUSY    = (state_q == StShow) || (state_q == StGap);
  assign LED_RGB = led_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter with short tick/hold/gap/blink
// settings. A table of {inputs, cycle count, expected outputs} rows is applied
// in order; expected LED values are masked by a bench-side free-running PWM
// count. A hand-written sequence checks PWM duty.
module tb_rgb_led_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] REQ = 3'b000;
  logic [2:0] COLOR0 = 3'b100;
  logic [2:0] COLOR1 = 3'b010;
  logic [2:0] COLOR2 = 3'b001;
  logic [2:0] BLINK = 3'b000;
  logic [7:0] BRIGHT = 8'd255;
  logic [2:0] GNT;
  logic       BUSY;
  logic [2:0] LED_RGB;

  rgb_led_arbiter #(
    .TICK_DIV   (4),
    .HOLD_TICKS (3),
    .GAP_TICKS  (2),
    .BLINK_TICKS(2)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .COLOR0 (COLOR0),
    .COLOR1 (COLOR1),
    .COLOR2 (COLOR2),
    .BLINK  (BLINK),
    .BRIGHT (BRIGHT),
    .GNT    (GNT),
    .BUSY   (BUSY),
    .LED_RGB(LED_RGB)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] blink;
    int         n;
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] led;   // colour expected if PWM is lit on that edge
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] pwm_m = 8'd0;  // bench model of the free-running PWM counter
  logic [7:0] pwm_before;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock; track PWM model; sample #1 after the edge.
  task automatic step();
    pwm_before = pwm_m;
    @(posedge CLK);
    pwm_m = RST ? 8'd0 : pwm_m + 8'd1;
    #1;
  endtask

  task automatic add(input logic rst, input logic [2:0] req, input logic [2:0] blink,
                     input int n, input logic [2:0] gnt, input logic busy, input logic [2:0] led);
    vec_t v;
    v.rst = rst; v.req = req; v.blink = blink; v.n = n;
    v.gnt = gnt; v.busy = busy; v.led = led;
    vecs.push_back(v);
  endtask

  task automatic apply_row(input int r, input vec_t v);
    logic [2:0] exp_led;
    RST   = v.rst;
    REQ   = v.req;
    BLINK = v.blink;
    for (int c = 0; c < v.n; c++) begin
      step();
      exp_led = (pwm_before < BRIGHT) ? v.led : 3'b000;
      check($sformatf("row%0d cyc%0d GNT", r, c), GNT, v.gnt);
      check($sformatf("row%0d cyc%0d BUSY", r, c), {2'b00, BUSY}, {2'b00, v.busy});
      check($sformatf("row%0d cyc%0d LED", r, c), LED_RGB, exp_led);
    end
  endtask

  initial begin
    int lit_cnt;
    int dark_bad;

    // Reset held with all requests asserted
    add(1, 3'b111, 3'b000, 2, 3'b000, 0, 3'b000);
    add(0, 3'b000, 3'b000, 3, 3'b000, 0, 3'b000);
    // Single 2-cycle pulse from requester 1
    add(0, 3'b010, 3'b000, 1, 3'b000, 0, 3'b000);
    add(0, 3'b010, 3'b000, 1, 3'b010, 1, 3'b000);
    add(0, 3'b000, 3'b000, 11, 3'b010, 1, 3'b010);
    add(0, 3'b000, 3'b000, 1, 3'b000, 1, 3'b010);
    add(0, 3'b000, 3'b000, 7, 3'b000, 1, 3'b000);
    add(0, 3'b000, 3'b000, 3, 3'b000, 0, 3'b000);
    // All three requesting: 0,1,2,0 in turn
    add(1, 3'b000, 3'b000, 2, 3'b000, 0, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b000, 0, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b001, 1, 3'b000);
    add(0, 3'b111, 3'b000, 11, 3'b001, 1, 3'b100);
    add(0, 3'b111, 3'b000, 1, 3'b000, 1, 3'b100);
    add(0, 3'b111, 3'b000, 7, 3'b000, 1, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b010, 1, 3'b000);
    add(0, 3'b111, 3'b000, 11, 3'b010, 1, 3'b010);
    add(0, 3'b111, 3'b000, 1, 3'b000, 1, 3'b010);
    add(0, 3'b111, 3'b000, 7, 3'b000, 1, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b100, 1, 3'b000);
    add(0, 3'b111, 3'b000, 11, 3'b100, 1, 3'b001);
    add(0, 3'b111, 3'b000, 1, 3'b000, 1, 3'b001);
    add(0, 3'b111, 3'b000, 7, 3'b000, 1, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b001, 1, 3'b000);
    add(0, 3'b111, 3'b000, 5, 3'b001, 1, 3'b100);
    // Reset mid-SHOW, then requester 0 first again
    add(1, 3'b111, 3'b000, 1, 3'b000, 0, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b000, 0, 3'b000);
    add(0, 3'b111, 3'b000, 1, 3'b001, 1, 3'b000);
    add(0, 3'b111, 3'b000, 3, 3'b001, 1, 3'b100);
    // Blinking sole owner beyond hold, then requester 1 joins
    add(1, 3'b000, 3'b000, 2, 3'b000, 0, 3'b000);
    add(0, 3'b001, 3'b001, 1, 3'b000, 0, 3'b000);
    add(0, 3'b001, 3'b001, 1, 3'b001, 1, 3'b000);
    add(0, 3'b001, 3'b001, 8, 3'b001, 1, 3'b100);
    add(0, 3'b001, 3'b001, 8, 3'b001, 1, 3'b000);
    add(0, 3'b001, 3'b001, 8, 3'b001, 1, 3'b100);
    add(0, 3'b001, 3'b001, 8, 3'b001, 1, 3'b000);
    add(0, 3'b011, 3'b001, 1, 3'b000, 1, 3'b100);
    add(0, 3'b011, 3'b001, 7, 3'b000, 1, 3'b000);
    add(0, 3'b011, 3'b001, 1, 3'b010, 1, 3'b000);
    add(0, 3'b011, 3'b001, 3, 3'b010, 1, 3'b010);
    // Reset ahead of the PWM sequence
    add(1, 3'b000, 3'b000, 2, 3'b000, 0, 3'b000);

    for (int r = 0; r < vecs.size(); r++) apply_row(r, vecs[r]);

    // PWM duty: requester 2 sole owner at BRIGHT=64, then BRIGHT=0
    BRIGHT = 8'd64;
    apply_row(100, '{rst: 1'b0, req: 3'b100, blink: 3'b000, n: 1,
                     gnt: 3'b000, busy: 1'b0, led: 3'b000});
    apply_row(101, '{rst: 1'b0, req: 3'b100, blink: 3'b000, n: 1,
                     gnt: 3'b100, busy: 1'b1, led: 3'b000});
    lit_cnt  = 0;
    dark_bad = 0;
    for (int c = 0; c < 256; c++) begin
      step();
      if (LED_RGB == 3'b001) lit_cnt++;
      else if (LED_RGB != 3'b000) dark_bad++;
    end
    check("pwm64 lit count", 3'(lit_cnt == 64), 3'd1);
    check("pwm64 stray colour", 3'(dark_bad), 3'd0);
    BRIGHT = 8'd0;
    step();
    lit_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      step();
      if (LED_RGB != 3'b000) lit_cnt++;
    end
    check("pwm0 lit count", 3'(lit_cnt != 0), 3'd0);
    check("pwm0 GNT held", GNT, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
